// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller.
//   MEM_DEPTH / MEM_WIDTH : default word count and data width
//   state_e               : controller FSM states
//   mem_req_t             : queued request record {we, addr, wdata} at default widths
package mem_pkg;

  localparam int unsigned MEM_DEPTH  = 32;
  localparam int unsigned MEM_WIDTH  = 8;
  localparam int unsigned MEM_ADDR_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RSP_HOLD
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_WIDTH-1:0]  wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Request queue for mem_access_ctrl: synchronous FIFO of request records.
//   clk, rst  : clock, synchronous active-high reset
//   i_push    : write i_din (ignored when full)
//   i_pop     : drop head entry (ignored when empty)
//   o_dout    : head entry (valid when !o_empty)
//   o_full    : QDEPTH entries held
//   o_empty   : no entries held
//   o_count   : number of entries held
// QDEPTH must be a power of two >= 2 so the pointers wrap naturally.
module mem_req_fifo
  import mem_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  parameter type         T      = mem_req_t,
  localparam int unsigned PTR_W = $clog2(QDEPTH),
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  T                 i_din,
  input  logic             i_pop,
  output T                 o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  T                 r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(QDEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // A full queue refuses the push even if the head is popped the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: queues read/write requests and issues them to a
// single-port memory strictly in acceptance order.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake; req_we/req_addr/req_wdata payload
//   rsp_valid/rsp_ready   : read response handshake; rsp_rdata payload
//   mem_read/mem_write    : one-cycle memory strobes (never both high)
//   mem_addr/mem_wdata    : memory address/data, held between strobes
//   mem_rdata             : memory read data, valid the cycle after mem_read
//   pend_cnt              : number of queued requests
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned WIDTH  = MEM_WIDTH,
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [CNT_W-1:0]  pend_cnt
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
  } req_t;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WIDTH-1:0]  r_mem_wdata;
  logic              r_rsp_valid;
  logic [WIDTH-1:0]  r_rsp_rdata;

  req_t              w_req;
  req_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_issue_rd;
  logic              w_issue_wr;
  logic              w_capture;
  logic              w_rsp_done;

  assign w_req     = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign req_ready = !w_full && !rst;
  assign w_push    = req_valid && req_ready;

  mem_req_fifo #(
    .QDEPTH (QDEPTH),
    .T      (req_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_req),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pend_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // RD_WAIT spans two cycles: the cycle mem_read is high, then the cycle
  // mem_rdata is valid. r_mem_read distinguishes the two without an extra state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:     if (!w_empty && !w_head.we) w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  if (!r_mem_read)            w_state_nxt = ST_RSP_HOLD;
      ST_RSP_HOLD: if (rsp_ready)              w_state_nxt = ST_IDLE;
      default:                                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop      = 1'b0;
    w_issue_rd = 1'b0;
    w_issue_wr = 1'b0;
    w_capture  = 1'b0;
    w_rsp_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_pop      = !w_empty;
        w_issue_rd = !w_empty && !w_head.we;
        w_issue_wr = !w_empty && w_head.we;
      end
      ST_RD_WAIT:  w_capture  = !r_mem_read;
      ST_RSP_HOLD: w_rsp_done = rsp_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_mem_read  <= w_issue_rd;
      r_mem_write <= w_issue_wr;
      if (w_pop)      r_mem_addr  <= w_head.addr;
      if (w_issue_wr) r_mem_wdata <= w_head.wdata;
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= mem_rdata;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule
